// File: rtl/xor_nbit_stream.sv
// xor_nbit_stream
// Streaming, registered bitwise XOR unit. Each accepted beat computes
// d = x ^ y and then applies a per-beat mode: XOR, XNOR, single-bit parity,
// or an XOR-checksum accumulated over a frame. There is one registered
// output beat per result.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for x, y, mode, in_last
//   x, y                 WIDTH-bit operands
//   mode                 00 XOR, 01 XNOR, 10 ACCUM, 11 PARITY
//   in_last              closes an ACCUM frame
//   out_valid/out_ready  output handshake for z, parity, ovf
//   z                    WIDTH-bit result
//   parity               XOR-reduction of z
//   ovf                  ACCUM frame force-closed at MAX_BEATS
//   busy                 an ACCUM frame is open
module xor_nbit_stream #(
    parameter int WIDTH     = 4,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             parity,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] MODE_XOR    = 2'b00;
    localparam logic [1:0] MODE_XNOR   = 2'b01;
    localparam logic [1:0] MODE_ACCUM  = 2'b10;
    localparam logic [1:0] MODE_PARITY = 2'b11;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] res;
    logic             emit;
    logic             ovf_n;
    logic             accept;

    // A held output only blocks the input if the sink is not taking it now,
    // so a full register still streams one beat per cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign d        = x ^ y;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign busy     = (state == ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        emit    = 1'b0;
        res     = d;
        ovf_n   = 1'b0;
        if (accept) begin
            case (mode)
                MODE_XOR: begin
                    emit = 1'b1;
                    res  = d;
                end
                MODE_XNOR: begin
                    emit = 1'b1;
                    res  = ~d;
                end
                MODE_PARITY: begin
                    emit   = 1'b1;
                    res    = '0;
                    res[0] = ^d;
                end
                MODE_ACCUM: begin
                    if (state == IDLE) begin
                        if (in_last) begin
                            // single-beat frame: result is d itself
                            emit = 1'b1;
                            res  = d;
                        end else begin
                            state_n = ACC;
                            acc_n   = d;
                            cnt_n   = CNT_W'(1);
                        end
                    end else if (in_last || cnt_inc == MAX_CNT) begin
                        emit    = 1'b1;
                        res     = acc ^ d;
                        ovf_n   = !in_last;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        acc_n = acc ^ d;
                        cnt_n = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Non-ACCUM beats inside an open frame go through the cases above
    // without touching acc/cnt/state, so the frame simply stays open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            parity    <= 1'b0;
            ovf       <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            z         <= res;
            parity    <= ^res;
            ovf       <= ovf_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_nbit_stream.sv
// Scoreboard bench for xor_nbit_stream (WIDTH=4, MAX_BEATS=4).
// The driver pushes the hand-computed expected result when it issues a
// producing beat; a monitor pops and compares on every output handshake.
module tb_xor_nbit_stream;

    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0] z;
        logic       parity;
        logic       ovf;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [1:0] mode = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] z;
    logic       parity;
    logic       ovf;
    logic       busy;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;

    xor_nbit_stream #(.WIDTH(WIDTH), .MAX_BEATS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .parity(parity), .ovf(ovf), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got z=%0h with empty scoreboard", z);
            end else begin
                exp_t e;
                e = q.pop_front();
                popped++;
                check({e.name, ".z"}, 32'(z), 32'(e.z));
                check({e.name, ".parity"}, 32'(parity), 32'(e.parity));
                check({e.name, ".ovf"}, 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic push(input logic [3:0] ez, input logic ep, input logic eo, input string nm);
        exp_t e;
        e.z = ez; e.parity = ep; e.ovf = eo; e.name = nm;
        q.push_back(e);
        pushed++;
    endtask

    // Issue one beat; returns #1 after the accepting edge.
    task automatic beat(input logic [3:0] xi, input logic [3:0] yi, input logic [1:0] m,
                        input logic l, input logic has_exp, input logic [3:0] ez,
                        input logic ep, input logic eo, input string nm);
        int n;
        in_valid = 1'b1; x = xi; y = yi; mode = m; in_last = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: in_ready=%0b expected 1", nm, in_ready);
        end
        if (has_exp) push(ez, ep, eo, nm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_z", 32'(z), 0);
        check("rst_parity", 32'(parity), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_out_valid", 32'(out_valid), 0);

        // plain modes
        beat(4'b1010, 4'b0110, 2'b00, 0, 1, 4'b1100, 0, 0, "xor_a");
        beat(4'hF, 4'h1, 2'b01, 0, 1, 4'h1, 1, 0, "xnor");
        beat(4'hF, 4'h1, 2'b11, 0, 1, 4'h1, 1, 0, "par");
        beat(4'hF, 4'h0, 2'b00, 1, 1, 4'hF, 0, 0, "xor_ones");
        beat(4'h6, 4'h6, 2'b11, 0, 1, 4'h0, 0, 0, "par_zero");

        // ACCUM frame 1,2,4 -> 7
        beat(4'h1, 4'h0, 2'b10, 0, 0, 0, 0, 0, "acc1");
        check("acc_busy1", 32'(busy), 1);
        beat(4'h2, 4'h0, 2'b10, 0, 0, 0, 0, 0, "acc2");
        check("acc_busy2", 32'(busy), 1);
        beat(4'h4, 4'h0, 2'b10, 1, 1, 4'h7, 1, 0, "acc_frame");
        check("acc_busy3", 32'(busy), 0);

        // overflow: 4 beats of 1 with no last -> 0, ovf=1
        for (int i = 0; i < 3; i++) beat(4'h1, 4'h0, 2'b10, 0, 0, 0, 0, 0, "ovf_beat");
        beat(4'h1, 4'h0, 2'b10, 0, 1, 4'h0, 0, 1, "ovf_frame");
        check("ovf_busy", 32'(busy), 0);

        // non-ACCUM beat inside an open frame
        beat(4'h3, 4'h0, 2'b10, 0, 0, 0, 0, 0, "mix_acc1");
        beat(4'h5, 4'h1, 2'b00, 0, 1, 4'h4, 1, 0, "mix_xor");
        check("mix_busy", 32'(busy), 1);
        beat(4'h8, 4'h0, 2'b10, 1, 1, 4'hB, 1, 0, "mix_frame");

        // back-pressure: A sits in the output while B waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(4'h9, 4'h0, 2'b00, 0, 1, 4'h9, 0, 0, "bp_a");
        in_valid = 1'b1; x = 4'h3; y = 4'h0; mode = 2'b01; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_z_held", 32'(z), 32'h9);
            check("bp_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(4'hC, 0, 0, "bp_b");
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // async reset mid-frame (cnt=2)
        beat(4'h1, 4'h0, 2'b10, 0, 0, 0, 0, 0, "rf1");
        beat(4'h2, 4'h0, 2'b10, 0, 0, 0, 0, 0, "rf2");
        check("rf_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rf_out_valid", 32'(out_valid), 0);
        check("rf_busy_clr", 32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        beat(4'h5, 4'h0, 2'b10, 1, 1, 4'h5, 0, 0, "post_rst");

        // drain
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", 32'(q.size()), 0);
        check("out_count", 32'(popped), 32'(pushed));
        check("end_out_valid", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
